// File: rtl/scp_arb_pkg.sv
// scp_arb_pkg: shared types and requester indices for the data-memory arbiter.
package scp_arb_pkg;
  typedef enum logic {IDLE, RESP} arb_state_e;
  localparam int REQ_CORE = 0;
  localparam int REQ_HOST = 1;
  localparam int NUM_REQ  = 2;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational 2-way picker; round-robin when DMEM_ARB_RR_EN is defined, else core-first.
module dmem_arb_pick
  import scp_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] valid,
`ifdef DMEM_ARB_RR_EN
  input  logic               last_grant,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output logic               idx
);
`ifdef DMEM_ARB_RR_EN
  assign idx = &valid ? ~last_grant : ~valid[REQ_CORE];
`else
  assign idx = ~valid[REQ_CORE];
`endif
  assign gnt = ~|valid ? '0 : (idx ? 2'b10 : 2'b01);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between core (0) and host loader (1), one access per two cycles.
// Policy macro: DMEM_ARB_RR_EN selects round-robin; default is fixed core priority.
module dmem_arbiter
  import scp_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0][DATA_W/8-1:0] req_be,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_W-1:0]                rsp_rdata,
  output logic                             rsp_err,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_wdata,
  output logic [DATA_W/8-1:0]              mem_be,
  input  logic [DATA_W-1:0]                mem_rdata
);
  arb_state_e         state, state_n;
  logic               grant_q, we_q, err_q, g, grant, ok, rsp;
  logic [NUM_REQ-1:0] gnt_oh;
`ifdef DMEM_ARB_RR_EN
  logic               last_grant;
  dmem_arb_pick u_pick (.valid(req_valid), .last_grant(last_grant), .gnt(gnt_oh), .idx(g));
`else
  dmem_arb_pick u_pick (.valid(req_valid), .gnt(gnt_oh), .idx(g));
`endif
  always_comb begin
    grant     = reset && state == IDLE && |req_valid;
    ok        = grant && req_addr[g][1:0] == 2'b00;
    state_n   = (state == IDLE && |req_valid) ? RESP : IDLE;
    req_ready = grant ? gnt_oh : '0;
    mem_en    = ok;
    mem_we    = ok && req_we[g];
    mem_addr  = ok ? {req_addr[g][ADDR_W-1:2], 2'b00} : '0;
    mem_wdata = ok ? req_wdata[g] : '0;
    mem_be    = ok ? req_be[g] : '0;
    // a response cut short by reset is suppressed rather than delivered
    rsp       = reset && state == RESP;
    rsp_valid = rsp ? (grant_q ? 2'b10 : 2'b01) : '0;
    rsp_err   = rsp && err_q;
    rsp_rdata = (rsp && !we_q && !err_q) ? mem_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      grant_q <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_grant <= 1'(REQ_HOST);
`endif
    end else begin
      state <= state_n;
      if (grant) begin
        grant_q <= g;
        we_q    <= req_we[g];
        err_q   <= req_addr[g][1:0] != 2'b00;
`ifdef DMEM_ARB_RR_EN
        last_grant <= g;
`endif
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus random traffic checked against a transaction-level model.
module tb_dmem_arbiter;
  logic             clk, reset, rsp_err, mem_en, mem_we;
  logic [1:0]       req_valid, req_ready, req_we, rsp_valid;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0][3:0]  req_be;
  logic [31:0]      rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]       mem_be;
  dmem_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  logic [31:0] env_mem [16];
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) if (mem_be[b]) env_mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else mem_rdata <= env_mem[mem_addr[5:2]];
    end
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  logic             rst_v;
  logic [1:0]       pv, pwe;
  logic [1:0][31:0] paddr, pwdata;
  logic [1:0][3:0]  pbe;
  logic [31:0]      sb [16];
  logic             m_busy, m_g, m_err, m_last;
  logic [31:0]      m_rd;
  int               grants [2];
  task automatic setreq(input int r, input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    pv[r] = 1; pwe[r] = we; paddr[r] = a; pwdata[r] = d; pbe[r] = be;
  endtask
  task automatic cyc();
    int w;
    logic [3:0] i;
    @(negedge clk);
    reset = rst_v; req_valid = pv; req_we = pwe; req_addr = paddr; req_wdata = pwdata; req_be = pbe;
    #4;
    if (!rst_v) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_mem_en", mem_en, 0);
      if (!m_busy) chk("rst_rsp_valid", rsp_valid, 0);
      m_busy = 0; m_last = 1;
    end else if (m_busy) begin
      chk("resp_ready", req_ready, 0);
      chk("resp_mem_en", mem_en, 0);
      chk("rsp_valid", rsp_valid, m_g ? 2'b10 : 2'b01);
      chk("rsp_err", rsp_err, m_err);
      chk("rsp_rdata", rsp_rdata, m_rd);
      m_busy = 0;
    end else begin
      chk("idle_rsp_valid", rsp_valid, 0);
      if (pv == 0) begin
        chk("none_ready", req_ready, 0);
        chk("none_mem_en", mem_en, 0);
        chk("none_mem_bus", {mem_addr, mem_wdata}, 0);
        chk("none_mem_be", mem_be, 0);
      end else begin
`ifdef DMEM_ARB_RR_EN
        w = (pv == 2'b11) ? int'(!m_last) : (pv[0] ? 0 : 1);
`else
        w = pv[0] ? 0 : 1;
`endif
        chk("grant", req_ready, 2'b01 << w);
        grants[w]++;
        m_err = paddr[w][1:0] != 0;
        m_rd = 0;
        chk("mem_en", mem_en, !m_err);
        if (!m_err) begin
          i = paddr[w][5:2];
          chk("mem_we", mem_we, pwe[w]);
          chk("mem_addr", mem_addr, paddr[w] & ~32'd3);
          if (pwe[w]) begin
            chk("mem_wdata", mem_wdata, pwdata[w]);
            chk("mem_be", mem_be, pbe[w]);
            for (int b = 0; b < 4; b++) if (pbe[w][b]) sb[i][8*b +: 8] = pwdata[w][8*b +: 8];
          end else m_rd = sb[i];
        end
        m_busy = 1; m_g = w[0]; m_last = w[0]; pv[w] = 0;
      end
    end
  endtask
  initial begin
    for (int k = 0; k < 16; k++) begin env_mem[k] = 0; sb[k] = 0; end
    mem_rdata = 0; m_busy = 0; m_last = 1; m_g = 0; m_err = 0; m_rd = 0;
    pv = 0; pwe = 0; paddr = 0; pwdata = 0; pbe = 0;
    reset = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0;
    rst_v = 0;
    setreq(0, 0, 32'h4, 0, 4'hF); setreq(1, 0, 32'h8, 0, 4'hF);
    cyc(); cyc();
    pv = 0; rst_v = 1;
    setreq(0, 1, 32'h10, 32'hDEADBEEF, 4'hF); cyc(); cyc();
    setreq(1, 0, 32'h10, 0, 4'hF); cyc(); cyc();
    chk("host_read_data", m_rd, 32'hDEADBEEF);
    setreq(0, 0, 32'h13, 0, 4'hF); cyc(); cyc();
    setreq(0, 1, 32'h24, 32'h12345678, 4'h3); cyc();
    rst_v = 0; cyc(); rst_v = 1; cyc();
    setreq(1, 0, 32'h24, 0, 4'hF); cyc(); cyc();
    grants[0] = 0; grants[1] = 0;
    for (int c = 0; c < 8; c++) begin
      if (!pv[0]) setreq(0, 0, 32'h20, 0, 4'hF);
      if (!pv[1]) setreq(1, 0, 32'h30, 0, 4'hF);
      cyc();
    end
`ifdef DMEM_ARB_RR_EN
    chk("both_core_grants", grants[0], 2);
    chk("both_host_grants", grants[1], 2);
`else
    chk("both_core_grants", grants[0], 4);
    chk("both_host_grants", grants[1], 0);
`endif
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < 2; r++)
        if (!pv[r] && $urandom_range(0, 2) == 0) begin
          paddr[r] = $urandom();
          if ($urandom_range(0, 3) != 0) paddr[r][1:0] = 0;
          setreq(r, 1'($urandom_range(0, 1)), paddr[r], $urandom(), 4'($urandom_range(0, 15)));
        end
      rst_v = $urandom_range(0, 49) != 0;
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
